// File: rtl/axi_slv_pkg.sv
// Shared types for the AXI3 write-path slave: burst kinds, response codes and FSM states.
package axi_slv_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        RESP = 2'b10
    } wr_state_e;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_calc.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
module axi_burst_addr_calc
    import axi_slv_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [2:0]        i_size,
    input  logic [3:0]        i_len,
    input  burst_e            i_burst,
    output logic [ADDR_W-1:0] o_next_addr
);

    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_incr;
    logic [ADDR_W-1:0] w_bound;
    logic [ADDR_W-1:0] w_mask;

    assign w_step  = ADDR_W'(1) << i_size;
    assign w_incr  = i_addr + w_step;
    assign w_bound = (ADDR_W'(i_len) + ADDR_W'(1)) << i_size;
    assign w_mask  = w_bound - ADDR_W'(1);

    always_comb begin
        o_next_addr = i_addr;
        case (i_burst)
            INCR:    o_next_addr = w_incr;
            WRAP:    o_next_addr = (i_addr & ~w_mask) | (w_incr & w_mask);
            default: o_next_addr = i_addr;
        endcase
    end

endmodule

// File: rtl/axi_slv_wr_mem.sv
// AXI3 write slave with byte-strobed internal memory and a combinational debug read port.
// Optional LFSR-driven W backpressure is enabled by defining AXI_SLV_WR_BP_EN.
module axi_slv_wr_mem
    import axi_slv_pkg::*;
#(
    parameter int unsigned ID_W      = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 256,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic                     aclk,
    input  logic                     arstn,
    input  logic [ID_W-1:0]          awid,
    input  logic [ADDR_W-1:0]        awaddr,
    input  logic [3:0]               awlen,
    input  logic [2:0]               awsize,
    input  logic [1:0]               awbrust,
    input  logic [1:0]               awlock,
    input  logic [3:0]               awcache,
    input  logic [2:0]               awprot,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [ID_W-1:0]          wid,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/8-1:0]      wstrob,
    input  logic                     wlast,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [ID_W-1:0]          bid,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    input  logic [$clog2(DEPTH)-1:0] dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
);

    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned ADDR_LSB = $clog2(STRB_W);
    localparam int unsigned IDX_W    = $clog2(DEPTH);

    wr_state_e         r_state;
    wr_state_e         w_state_nxt;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [3:0]        r_len;
    logic [3:0]        r_cnt;
    logic [2:0]        r_size;
    burst_e            r_burst;
    logic              r_err;
    logic              r_nowr;
    logic              r_awready;
    logic              r_wready;
    logic              r_bvalid;
    logic [1:0]        r_bresp;
    logic [ID_W-1:0]   r_bid;
    logic              w_awready_nxt;
    logic              w_wready_nxt;
    logic              w_bvalid_nxt;
    logic              w_bp_ok;

    logic [DATA_W-1:0] r_mem [DEPTH];

    burst_e            w_aw_burst;
    logic [ADDR_W-1:0] w_size_mask;
    logic              w_aw_err;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_b_hs;
    logic              w_cnt_end;
    logic              w_last_beat;
    logic              w_id_err;
    logic              w_beat_err;
    logic              w_wr_en;
    logic [IDX_W-1:0]  w_idx;
    logic              w_unused;

    assign w_unused = ^{awlock, awcache, awprot, LFSR_SEED};

    assign w_aw_burst  = burst_e'(awbrust);
    assign w_size_mask = (ADDR_W'(1) << awsize) - ADDR_W'(1);
    assign w_aw_err    = (awsize > 3'(ADDR_LSB)) || (w_aw_burst == RSVD) ||
                         ((w_aw_burst == WRAP) &&
                          (!wrap_len_ok(awlen) || ((awaddr & w_size_mask) != '0)));

    assign w_aw_hs     = (r_state == IDLE) && awvalid && r_awready;
    assign w_w_hs      = (r_state == DATA) && wvalid && r_wready;
    assign w_b_hs      = r_bvalid && bready;
    assign w_cnt_end   = (r_cnt == r_len);
    assign w_last_beat = w_w_hs && w_cnt_end;
    assign w_id_err    = (wid != r_id);
    // A misplaced wlast is flagged but the beat still lands; a foreign wid does not.
    assign w_beat_err  = w_w_hs && (w_id_err || (wlast != w_cnt_end));
    assign w_wr_en     = w_w_hs && !r_nowr && !w_id_err;
    assign w_idx       = r_addr[ADDR_LSB +: IDX_W];

    axi_burst_addr_calc #(
        .ADDR_W (ADDR_W)
    ) u_addr_calc (
        .i_addr      (r_addr),
        .i_size      (r_size),
        .i_len       (r_len),
        .i_burst     (r_burst),
        .o_next_addr (w_addr_nxt)
    );

`ifdef AXI_SLV_WR_BP_EN
    logic [7:0] r_lfsr;
    logic [7:0] w_lfsr_nxt;

    assign w_lfsr_nxt = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    // Registered wready follows the LFSR value it will have in the next cycle.
    assign w_bp_ok    = w_lfsr_nxt[0];

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= w_lfsr_nxt;
        end
    end
`else
    assign w_bp_ok = 1'b1;
`endif

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_aw_hs)     w_state_nxt = DATA;
            DATA:    if (w_last_beat) w_state_nxt = RESP;
            RESP:    if (w_b_hs)      w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // awready rises only after a full cycle in IDLE, giving one idle cycle per burst.
    always_comb begin
        w_awready_nxt = (r_state == IDLE) && (w_state_nxt == IDLE);
        w_wready_nxt  = (w_state_nxt == DATA) && w_bp_ok;
        w_bvalid_nxt  = (w_state_nxt == RESP);
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_bid     <= '0;
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_size    <= '0;
            r_burst   <= FIXED;
            r_err     <= 1'b0;
            r_nowr    <= 1'b0;
        end else begin
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            if (w_aw_hs) begin
                r_id    <= awid;
                r_addr  <= awaddr;
                r_len   <= awlen;
                r_size  <= awsize;
                r_burst <= w_aw_burst;
                r_cnt   <= '0;
                r_err   <= w_aw_err;
                r_nowr  <= w_aw_err;
            end
            if (w_w_hs) begin
                r_cnt  <= r_cnt + 4'd1;
                r_addr <= w_addr_nxt;
                if (w_beat_err) begin
                    r_err <= 1'b1;
                end
            end
            if (w_last_beat) begin
                r_bid   <= r_id;
                r_bresp <= (r_err || w_beat_err) ? SLVERR : OKAY;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_wr_en) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrob[i]) begin
                    r_mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign awready  = r_awready;
    assign wready   = r_wready;
    assign bvalid   = r_bvalid;
    assign bresp    = r_bresp;
    assign bid      = r_bid;
    assign dbg_data = r_mem[dbg_addr];

endmodule
